// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE pending-bit array.
//   bp_cce_pb_state_e : quiesce FSM states
//     e_run   - increments accepted
//     e_drain - increments blocked, waiting for every counter to reach zero
//     e_quiet - drained and blocked until resume
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_drain = 2'd1,
    e_quiet = 2'd2
  } bp_cce_pb_state_e;

endpackage

// File: rtl/bp_cce_pb_wg_hash.sv
// Maps a way-group address to a way-group index.
//   addr        : way-group address
//   bypass_hash : 1 selects addr[lg_wg-1:0] directly
//   wg          : way-group index
// The hashed path bit-reverses the address and bank-hashes it across num_cce_p
// CCEs (power-of-two banking: the bank is the low bits of the reversed address,
// the in-bank index is the rest); the way group is the low bits of that index.
module bp_cce_pb_wg_hash #(
  parameter int unsigned num_way_groups_p = 8,
  parameter int unsigned num_cce_p        = 2,
  parameter int unsigned addr_width_p     = 8
) (
  input  logic [addr_width_p-1:0]              addr,
  input  logic                                 bypass_hash,
  output logic [$clog2(num_way_groups_p)-1:0]  wg
);

  localparam int unsigned lg_wg_lp  = $clog2(num_way_groups_p);
  localparam int unsigned lg_cce_lp = $clog2(num_cce_p);

  logic [addr_width_p-1:0] rev;
  logic [addr_width_p-1:0] index;
  logic                    unused_index;

  always_comb begin
    rev = '0;
    for (int i = 0; i < int'(addr_width_p); i++) begin
      rev[i] = addr[int'(addr_width_p) - 1 - i];
    end
  end

  assign index        = rev >> lg_cce_lp;
  // Upper index bits beyond the way-group range are not needed here.
  assign unused_index = ^index;

  assign wg = bypass_hash ? addr[lg_wg_lp-1:0] : index[lg_wg_lp-1:0];

endmodule

// File: rtl/bp_cce_pending_bits_mp.sv
// Multi-port pending-bit array: one saturating counter per way group.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   inc_*                 : write port 0 (increment, or clear when inc_clear_i)
//   inc_ready_o           : port 0 may accept an increment (clears always accepted)
//   dec_*                 : write port 1 (decrement), always accepted
//   r_v_i/r_addr_i/...    : combinational read ports, forwarded from next state
//   pending_o, count_o    : per-read-port result, zero when r_v_i[k] is low
//   nonzero_count_o       : number of non-zero counters (registered)
//   quiesce_v_i, resume_i : drain request / leave quiet state (pulses)
//   quiesce_done_o        : drained and blocked
//   overflow_o/underflow_o: sticky saturation-event flags
// num_way_groups_p must be a power of two.
module bp_cce_pending_bits_mp
  import bp_cce_pkg::*;
#(
  parameter int unsigned num_way_groups_p = 8,
  parameter int unsigned num_cce_p        = 2,
  parameter int unsigned addr_width_p     = 8,
  parameter int unsigned width_p          = 3,
  parameter int unsigned num_r_ports_p    = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   inc_v_i,
  output logic                                   inc_ready_o,
  input  logic [addr_width_p-1:0]                inc_addr_i,
  input  logic                                   inc_bypass_hash_i,
  input  logic                                   inc_clear_i,
  input  logic                                   dec_v_i,
  input  logic [addr_width_p-1:0]                dec_addr_i,
  input  logic                                   dec_bypass_hash_i,
  input  logic [num_r_ports_p-1:0]               r_v_i,
  input  logic [num_r_ports_p*addr_width_p-1:0]  r_addr_i,
  input  logic [num_r_ports_p-1:0]               r_bypass_hash_i,
  output logic [num_r_ports_p-1:0]               pending_o,
  output logic [num_r_ports_p*width_p-1:0]       count_o,
  output logic [$clog2(num_way_groups_p+1)-1:0]  nonzero_count_o,
  input  logic                                   quiesce_v_i,
  input  logic                                   resume_i,
  output logic                                   quiesce_done_o,
  output logic                                   overflow_o,
  output logic                                   underflow_o
);

  localparam int unsigned lg_wg_lp    = $clog2(num_way_groups_p);
  localparam int unsigned nz_width_lp = $clog2(num_way_groups_p + 1);
  localparam logic [width_p-1:0] max_count_lp = '1;

  logic [lg_wg_lp-1:0] inc_wg;
  logic [lg_wg_lp-1:0] dec_wg;
  logic [lg_wg_lp-1:0] r_wg [num_r_ports_p];

  bp_cce_pb_wg_hash #(
    .num_way_groups_p(num_way_groups_p),
    .num_cce_p       (num_cce_p),
    .addr_width_p    (addr_width_p)
  ) inc_hash (
    .addr       (inc_addr_i),
    .bypass_hash(inc_bypass_hash_i),
    .wg         (inc_wg)
  );

  bp_cce_pb_wg_hash #(
    .num_way_groups_p(num_way_groups_p),
    .num_cce_p       (num_cce_p),
    .addr_width_p    (addr_width_p)
  ) dec_hash (
    .addr       (dec_addr_i),
    .bypass_hash(dec_bypass_hash_i),
    .wg         (dec_wg)
  );

  for (genvar k = 0; k < int'(num_r_ports_p); k++) begin : g_r_hash
    bp_cce_pb_wg_hash #(
      .num_way_groups_p(num_way_groups_p),
      .num_cce_p       (num_cce_p),
      .addr_width_p    (addr_width_p)
    ) r_hash (
      .addr       (r_addr_i[k*addr_width_p +: addr_width_p]),
      .bypass_hash(r_bypass_hash_i[k]),
      .wg         (r_wg[k])
    );
  end

  bp_cce_pb_state_e state_q, state_d;
  logic [width_p-1:0]     cnt_q [num_way_groups_p];
  logic [width_p-1:0]     cnt_d [num_way_groups_p];
  logic [nz_width_lp-1:0] nz_q, nz_d, nz_up, nz_dn;
  logic                   ovf_q, unf_q, ovf_evt, unf_evt;

  // Clears bypass the quiesce gate; only increments need inc_ready_o.
  logic inc_fire, clr_fire, add_fire;
  assign inc_fire = inc_v_i & (inc_clear_i | inc_ready_o);
  assign clr_fire = inc_fire & inc_clear_i;
  assign add_fire = inc_fire & ~inc_clear_i;

  logic [num_way_groups_p-1:0] hit_clr, hit_inc, hit_dec;

  always_comb begin
    hit_clr = '0;
    hit_inc = '0;
    hit_dec = '0;
    for (int i = 0; i < int'(num_way_groups_p); i++) begin
      hit_clr[i] = clr_fire & (inc_wg == lg_wg_lp'(i));
      hit_inc[i] = add_fire & (inc_wg == lg_wg_lp'(i));
      hit_dec[i] = dec_v_i  & (dec_wg == lg_wg_lp'(i));
    end
  end

  always_comb begin
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    nz_up   = '0;
    nz_dn   = '0;
    for (int i = 0; i < int'(num_way_groups_p); i++) begin
      cnt_d[i] = cnt_q[i];
      if (hit_clr[i]) begin
        // A colliding decrement is absorbed by the clear, no underflow.
        cnt_d[i] = '0;
      end else if (hit_inc[i] && hit_dec[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (hit_inc[i]) begin
        if (cnt_q[i] == max_count_lp) ovf_evt = 1'b1;
        else                          cnt_d[i] = cnt_q[i] + width_p'(1);
      end else if (hit_dec[i]) begin
        if (cnt_q[i] == '0) unf_evt = 1'b1;
        else                cnt_d[i] = cnt_q[i] - width_p'(1);
      end
      if ((cnt_q[i] == '0) && (cnt_d[i] != '0)) nz_up = nz_up + nz_width_lp'(1);
      if ((cnt_q[i] != '0) && (cnt_d[i] == '0)) nz_dn = nz_dn + nz_width_lp'(1);
    end
    nz_d = nz_q + nz_up - nz_dn;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_run:   if (quiesce_v_i)      state_d = e_drain;
      e_drain: if (nz_d == '0)       state_d = e_quiet;
      e_quiet: if (resume_i)         state_d = e_run;
      default:                       state_d = e_run;
    endcase
  end

  assign inc_ready_o     = (state_q == e_run);
  assign quiesce_done_o  = (state_q == e_quiet);
  assign nonzero_count_o = nz_q;
  assign overflow_o      = ovf_q;
  assign underflow_o     = unf_q;

  always_comb begin
    pending_o = '0;
    count_o   = '0;
    for (int k = 0; k < int'(num_r_ports_p); k++) begin
      if (r_v_i[k]) begin
        pending_o[k]                = (cnt_d[r_wg[k]] != '0);
        count_o[k*width_p +: width_p] = cnt_d[r_wg[k]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(num_way_groups_p); i++) cnt_q[i] <= '0;
      nz_q    <= '0;
      state_q <= e_run;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(num_way_groups_p); i++) cnt_q[i] <= cnt_d[i];
      nz_q    <= nz_d;
      state_q <= state_d;
      ovf_q   <= ovf_q | ovf_evt;
      unf_q   <= unf_q | unf_evt;
    end
  end

endmodule

// File: tb/tb_bp_cce_pending_bits_mp.sv
module tb_bp_cce_pending_bits_mp;

  localparam int NWG  = 8;
  localparam int NCCE = 2;
  localparam int AW   = 8;
  localparam int W    = 3;
  localparam int NR   = 2;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              inc_v, inc_byp, inc_clear, inc_ready;
  logic [AW-1:0]     inc_addr;
  logic              dec_v, dec_byp;
  logic [AW-1:0]     dec_addr;
  logic [NR-1:0]     r_v, r_byp, pending;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*W-1:0]   count;
  logic [3:0]        nz_count;
  logic              quiesce_v, resume, done, ovf, unf;

  bp_cce_pending_bits_mp #(
    .num_way_groups_p(NWG),
    .num_cce_p       (NCCE),
    .addr_width_p    (AW),
    .width_p         (W),
    .num_r_ports_p   (NR)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .inc_v_i          (inc_v),
    .inc_ready_o      (inc_ready),
    .inc_addr_i       (inc_addr),
    .inc_bypass_hash_i(inc_byp),
    .inc_clear_i      (inc_clear),
    .dec_v_i          (dec_v),
    .dec_addr_i       (dec_addr),
    .dec_bypass_hash_i(dec_byp),
    .r_v_i            (r_v),
    .r_addr_i         (r_addr),
    .r_bypass_hash_i  (r_byp),
    .pending_o        (pending),
    .count_o          (count),
    .nonzero_count_o  (nz_count),
    .quiesce_v_i      (quiesce_v),
    .resume_i         (resume),
    .quiesce_done_o   (done),
    .overflow_o       (ovf),
    .underflow_o      (unf)
  );

  typedef struct {
    logic [NR-1:0]   pend;
    logic [NR*W-1:0] cnt;
    logic [3:0]      nz;
    logic            rdy, done, ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: plain integer counters and a symbolic FSM (0 run, 1 drain, 2 quiet).
  int   mc [NWG];
  int   mst = 0;
  bit   movf = 0, munf = 0, started = 0;

  function automatic int wg_of(input logic [AW-1:0] a, input logic byp);
    int rev = 0;
    if (byp) return int'(a) % NWG;
    for (int i = 0; i < AW; i++) rev = rev * 2 + int'(a[i]);
    return (rev / NCCE) % NWG;
  endfunction

  task automatic idle();
    reset = 0; inc_v = 0; inc_addr = '0; inc_byp = 0; inc_clear = 0;
    dec_v = 0; dec_addr = '0; dec_byp = 0;
    r_v = '0; r_addr = '0; r_byp = '0; quiesce_v = 0; resume = 0;
  endtask

  // Applies the currently driven inputs for one cycle; called at posedge+1.
  task automatic tick();
    int   nx [NWG];
    int   iw, dw, v, d, wg, pop_nx;
    bit   ifire, o, u;
    exp_t e;
    ifire = inc_v && (inc_clear || mst == 0);
    iw = wg_of(inc_addr, inc_byp);
    dw = wg_of(dec_addr, dec_byp);
    o = 0; u = 0;
    for (int i = 0; i < NWG; i++) begin
      if (ifire && inc_clear && iw == i) begin
        nx[i] = 0;
      end else begin
        d = 0;
        if (ifire && !inc_clear && iw == i) d += 1;
        if (dec_v && dw == i) d -= 1;
        v = mc[i] + d;
        if (v > MAXC) begin v = MAXC; o = 1; end
        if (v < 0)    begin v = 0;    u = 1; end
        nx[i] = v;
      end
    end
    e.pend = '0; e.cnt = '0; e.nz = '0;
    for (int k = 0; k < NR; k++) begin
      wg = wg_of(r_addr[k*AW +: AW], r_byp[k]);
      if (r_v[k]) begin
        e.pend[k] = (nx[wg] != 0);
        e.cnt[k*W +: W] = W'(nx[wg]);
      end
    end
    pop_nx = 0;
    for (int i = 0; i < NWG; i++) begin
      if (mc[i] != 0) e.nz = e.nz + 4'd1;
      if (nx[i] != 0) pop_nx++;
    end
    e.rdy = (mst == 0); e.done = (mst == 2); e.ovf = movf; e.unf = munf;
    if (started) exp_q.push_back(e);
    if (reset) begin
      for (int i = 0; i < NWG; i++) mc[i] = 0;
      mst = 0; movf = 0; munf = 0; started = 1;
    end else begin
      for (int i = 0; i < NWG; i++) mc[i] = nx[i];
      movf |= o; munf |= u;
      if (mst == 0 && quiesce_v)        mst = 1;
      else if (mst == 1 && pop_nx == 0) mst = 2;
      else if (mst == 2 && resume)      mst = 0;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic set_inc(input int wg, input bit clr);
    inc_v = 1; inc_addr = AW'(wg); inc_byp = 1; inc_clear = clr;
  endtask

  task automatic set_dec(input int wg);
    dec_v = 1; dec_addr = AW'(wg); dec_byp = 1;
  endtask

  task automatic set_rd(input int k, input int wg);
    r_v[k] = 1; r_addr[k*AW +: AW] = AW'(wg); r_byp[k] = 1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pending",        int'(pending),   int'(e.pend));
        chk("count",          int'(count),     int'(e.cnt));
        chk("nonzero_count",  int'(nz_count),  int'(e.nz));
        chk("inc_ready",      int'(inc_ready), int'(e.rdy));
        chk("quiesce_done",   int'(done),      int'(e.done));
        chk("overflow",       int'(ovf),       int'(e.ovf));
        chk("underflow",      int'(unf),       int'(e.unf));
      end
    end
  end

  initial begin
    for (int i = 0; i < NWG; i++) mc[i] = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 1; tick();
    reset = 1; tick();

    // Same-cycle forwarding on wg 3.
    set_inc(3, 0); tick();
    set_inc(3, 0); set_rd(0, 3); tick();
    set_rd(0, 3); set_rd(1, 3); tick();

    // Saturation on wg 0, underflow on wg 5.
    for (int i = 0; i < 8; i++) begin set_inc(0, 0); set_rd(1, 0); tick(); end
    set_rd(0, 0); tick();
    set_dec(5); set_rd(0, 5); tick();
    tick();

    // Collisions on wg 2.
    set_inc(2, 0); tick();
    set_inc(2, 0); set_dec(2); set_rd(0, 2); tick();
    set_inc(2, 1); set_dec(2); set_rd(0, 2); tick();

    // Independent way groups.
    set_inc(4, 0); tick();
    set_inc(1, 0); set_dec(4); set_rd(0, 1); set_rd(1, 4); tick();
    tick();

    // Quiesce and resume.
    reset = 1; tick();
    set_inc(1, 0); tick();
    set_inc(1, 0); tick();
    set_inc(6, 0); tick();
    quiesce_v = 1; tick();
    set_inc(7, 0); set_dec(1); tick();
    set_dec(1); tick();
    set_dec(6); set_rd(0, 6); tick();
    set_inc(7, 0); set_rd(0, 7); tick();
    resume = 1; tick();
    set_inc(7, 0); tick();
    tick();

    // Quiesce with everything already drained.
    reset = 1; tick();
    quiesce_v = 1; tick();
    tick(); tick();
    resume = 1; tick();

    // Reset in the middle of a drain.
    set_inc(5, 0); tick();
    quiesce_v = 1; tick();
    set_rd(0, 5); tick();
    reset = 1; tick();
    set_rd(0, 5); tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(99) == 0);
      inc_v     = $urandom_range(1);
      inc_addr  = AW'($urandom);
      inc_byp   = $urandom_range(1);
      inc_clear = ($urandom_range(9) == 0);
      dec_v     = $urandom_range(1);
      dec_addr  = AW'($urandom);
      dec_byp   = $urandom_range(1);
      r_v       = reset ? '0 : NR'($urandom);
      r_addr    = (NR*AW)'($urandom);
      r_byp     = NR'($urandom);
      quiesce_v = ($urandom_range(19) == 0);
      resume    = ($urandom_range(9) == 0);
      tick();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
